// File: rtl/conv_pkg.sv
// conv_pkg: shared fixed-point width helpers, FSM state type and pipeline tag layout
// for the convolution engine.
package conv_pkg;

  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_INT_WIDTH   = 12;
  localparam int DEF_FRAC_WIDTH  = 20;
  localparam int DEF_NUM_CH      = 4;

  // Sideband carried alongside each window through the dot-product stages.
  localparam int TAG_W     = 2;
  localparam int TAG_FIRST = 1;
  localparam int TAG_LAST  = 0;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_IDLE  = 2'd1,
    S_ACC   = 2'd2
  } conv_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int total_w, input int terms);
    return total_w + $clog2(terms) + 1;
  endfunction

  // Shifted products keep 2*TW-FW bits, so the running sum is sized to whichever is wider.
  function automatic int sum_width(input int total_w, input int frac_w, input int terms);
    int aw;
    int pw;
    aw = acc_width(total_w, terms);
    pw = acc_width(2 * total_w - frac_w, terms);
    return (pw > aw) ? pw : aw;
  endfunction

endpackage

// File: rtl/conv_dot.sv
// conv_dot: KK-tap signed fixed-point multiply (stage 1) and tap adder tree (stage 2),
// with a valid/tag sideband. Both stages hold when en is low.
module conv_dot
  import conv_pkg::*;
#(
  parameter int KK = 9,
  parameter int TW = 32,
  parameter int FW = 20,
  parameter int SW = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [KK-1:0][TW-1:0] din,
  input  logic [KK-1:0][TW-1:0] wt,
  output logic                  busy,
  output logic                  out_valid,
  output logic [TAG_W-1:0]      out_tag,
  output logic signed [SW-1:0]  out_sum
);
  localparam int PW = 2 * TW - FW;

  logic signed [2*TW-1:0] full;
  logic signed [PW-1:0]   prod_d [KK];
  logic signed [PW-1:0]   prod_q [KK];
  logic signed [SW-1:0]   sum_d, sum_q;
  logic                   valid1_d, valid1_q, valid2_d, valid2_q;
  logic [TAG_W-1:0]       tag1_d, tag1_q, tag2_d, tag2_q;

  always_comb begin
    full = '0;
    for (int unsigned i = 0; i < KK; i++) begin
      full      = (2*TW)'($signed(din[i])) * (2*TW)'($signed(wt[i]));
      prod_d[i] = en ? PW'(full >>> FW) : prod_q[i];
    end
    sum_d = sum_q;
    if (en) begin
      sum_d = '0;
      for (int unsigned i = 0; i < KK; i++) sum_d = sum_d + SW'(prod_q[i]);
    end
    valid1_d = en ? in_valid : valid1_q;
    tag1_d   = en ? in_tag   : tag1_q;
    valid2_d = en ? valid1_q : valid2_q;
    tag2_d   = en ? tag1_q   : tag2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < KK; i++) prod_q[i] <= '0;
      sum_q    <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      tag1_q   <= '0;
      tag2_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
      sum_q    <= sum_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag2_d;
    end
  end

  assign busy      = valid1_q | valid2_q;
  assign out_valid = valid2_q;
  assign out_tag   = tag2_q;
  assign out_sum   = sum_q;

endmodule

// File: rtl/conv_engine.sv
// conv_engine: multi-channel KxK fixed-point convolution with per-channel weight banks.
// Define CONV_SATURATE_EN to clip results to TOTAL_WIDTH (sat_flag); otherwise results wrap.
module conv_engine
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int INT_WIDTH   = DEF_INT_WIDTH,
  parameter int FRAC_WIDTH  = DEF_FRAC_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE,
  localparam int TW   = INT_WIDTH + FRAC_WIDTH,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [CH_W-1:0]       w_ch,
  input  logic [KK-1:0][TW-1:0] weights,
  input  logic                  win_valid,
  output logic                  win_ready,
  input  logic [KK-1:0][TW-1:0] din,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic signed [TW-1:0]  dout,
  output logic                  sat_flag
);
  localparam int SW = sum_width(TW, FRAC_WIDTH, KK * NUM_CH);

  conv_state_e           state_d, state_q;
  logic [NUM_CH-1:0]     loaded_d, loaded_q;
  logic [CH_W-1:0]       ch_d, ch_q;
  logic [KK-1:0][TW-1:0] bank_d [NUM_CH];
  logic [KK-1:0][TW-1:0] bank_q [NUM_CH];
  logic                  rdy_en_d, rdy_en_q;
  logic signed [SW-1:0]  acc_d, acc_q;
  logic                  acc_valid_d, acc_valid_q;
  logic [TW-1:0]         dout_d, dout_q, clip;
  logic                  sat_d, sat_q, clipped;
  logic                  dout_valid_d, dout_valid_q;

  logic                  stall, advance, w_fire, win_fire, last_ch;
  logic                  dot_busy, dot_valid;
  logic [TAG_W-1:0]      dot_tag, win_tag;
  logic signed [SW-1:0]  dot_sum;

  // A held, unconsumed result freezes the whole pipeline.
  assign stall    = dout_valid_q & ~dout_ready;
  assign advance  = ~stall;
  assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));
  assign w_ready  = rdy_en_q & (state_q != S_ACC) & ~dot_busy & ~acc_valid_q;
  assign win_ready = rdy_en_q & ~stall &
                     ((state_q == S_ACC) | ((state_q == S_IDLE) & ~w_valid));
  assign w_fire   = w_valid & w_ready;
  assign win_fire = win_valid & win_ready;

  always_comb begin
    win_tag            = '0;
    win_tag[TAG_FIRST] = (ch_q == '0);
    win_tag[TAG_LAST]  = last_ch;
  end

  conv_dot #(.KK(KK), .TW(TW), .FW(FRAC_WIDTH), .SW(SW)) u_dot (
    .clk       (clk),
    .rst       (rst),
    .en        (advance),
    .in_valid  (win_fire),
    .in_tag    (win_tag),
    .din       (din),
    .wt        (bank_q[ch_q]),
    .busy      (dot_busy),
    .out_valid (dot_valid),
    .out_tag   (dot_tag),
    .out_sum   (dot_sum)
  );

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    ch_d     = ch_q;
    bank_d   = bank_q;
    rdy_en_d = 1'b1;
    if (w_fire && (int'(w_ch) < NUM_CH)) begin
      bank_d[w_ch]   = weights;
      loaded_d[w_ch] = 1'b1;
      if ((state_q == S_EMPTY) && (&loaded_d)) state_d = S_IDLE;
    end
    if (win_fire) begin
      if (last_ch) begin
        ch_d    = '0;
        state_d = S_IDLE;
      end else begin
        ch_d    = ch_q + 1'b1;
        state_d = S_ACC;
      end
    end
  end

  always_comb begin
    acc_d        = acc_q;
    acc_valid_d  = acc_valid_q;
    dout_d       = dout_q;
    sat_d        = sat_q;
    dout_valid_d = dout_valid_q;
    clip         = acc_q[TW-1:0];
    clipped      = 1'b0;
`ifdef CONV_SATURATE_EN
    if (acc_q[SW-1:TW-1] != {(SW-TW+1){acc_q[SW-1]}}) begin
      clipped = 1'b1;
      clip    = acc_q[SW-1] ? {1'b1, {(TW-1){1'b0}}} : {1'b0, {(TW-1){1'b1}}};
    end
`endif
    if (advance) begin
      acc_valid_d = 1'b0;
      if (dot_valid) begin
        acc_d       = (dot_tag[TAG_FIRST] ? '0 : acc_q) + dot_sum;
        acc_valid_d = dot_tag[TAG_LAST];
      end
      dout_valid_d = acc_valid_q;
      if (acc_valid_q) begin
        dout_d = clip;
        sat_d  = clipped;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      loaded_q     <= '0;
      ch_q         <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) bank_q[c] <= '0;
      rdy_en_q     <= 1'b0;
      acc_q        <= '0;
      acc_valid_q  <= 1'b0;
      dout_q       <= '0;
      sat_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      ch_q         <= ch_d;
      for (int unsigned c = 0; c < NUM_CH; c++) bank_q[c] <= bank_d[c];
      rdy_en_q     <= rdy_en_d;
      acc_q        <= acc_d;
      acc_valid_q  <= acc_valid_d;
      dout_q       <= dout_d;
      sat_q        <= sat_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign sat_flag   = sat_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed and randomized checks of conv_engine (3x3, Q12.20, 2 channels)
// against an arithmetic reference model and an in-order result scoreboard.
module tb_conv_engine;
  localparam int KS  = 3;
  localparam int IW  = 12;
  localparam int FW  = 20;
  localparam int NCH = 2;
  localparam int KK  = KS * KS;
  localparam int TW  = IW + FW;
  localparam logic [31:0] ONE     = 32'h0010_0000;
  localparam logic [31:0] NEGHALF = 32'hFFF8_0000;
  localparam logic [31:0] BIG     = 32'h7FF0_0000;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef logic [KK-1:0][TW-1:0] vec_t;
  typedef struct packed { logic [31:0] d; logic s; } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid, w_ready, win_valid, win_ready;
  logic        dout_valid, dout_ready, sat_flag;
  logic [0:0]  w_ch;
  vec_t        weights, din;
  logic [31:0] dout;

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic signed [31:0] wm [NCH][KK];
  longint      part_m;
  int          ch_m;
  logic        held_v;
  logic [31:0] held_d;
  logic        held_s;

  conv_engine #(.KERNEL_SIZE(KS), .INT_WIDTH(IW), .FRAC_WIDTH(FW), .NUM_CH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_ch       (w_ch),
    .weights    (weights),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic vec_t fill(input logic [31:0] v);
    vec_t r;
    for (int i = 0; i < KK; i++) r[i] = v;
    return r;
  endfunction

  function automatic vec_t rand_vec(input int mode);
    vec_t r;
    for (int i = 0; i < KK; i++)
      r[i] = (mode == 0) ? $urandom : (32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000);
    return r;
  endfunction

  // Real-valued dot product: each tap is floor(w*x / 2^FW), summed without bound.
  function automatic longint dot_m(input int c, input vec_t x);
    longint s, a, b;
    s = 0;
    for (int i = 0; i < KK; i++) begin
      a = longint'(wm[c][i]);
      b = longint'($signed(x[i]));
      s += (a * b) >>> FW;
    end
    return s;
  endfunction

  function automatic exp_t to_exp(input longint s);
    exp_t e;
    logic [63:0] v;
    v = s;
    e.d = v[31:0];
    e.s = 1'b0;
`ifdef CONV_SATURATE_EN
    if (s > MAXV) begin e.d = 32'h7FFF_FFFF; e.s = 1'b1; end
    else if (s < MINV) begin e.d = 32'h8000_0000; e.s = 1'b1; end
`endif
    return e;
  endfunction

  task automatic send_w(input int c, input vec_t w);
    int n = 0;
    w_valid = 1'b1; w_ch = 1'(c); weights = w;
    @(negedge clk);
    while (!w_ready && n < 50) begin n++; @(negedge clk); end
    check("w_accept", w_ready, 1'b1);
    if (w_ready) for (int i = 0; i < KK; i++) wm[c][i] = w[i];
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_win(input vec_t x);
    int n = 0;
    win_valid = 1'b1; din = x;
    @(negedge clk);
    while (!win_ready && n < 50) begin n++; @(negedge clk); end
    check("win_accept", win_ready, 1'b1);
    if (win_ready) begin
      if (ch_m == 0) part_m = 0;
      part_m += dot_m(ch_m, x);
      if (ch_m == NCH - 1) begin
        exp_q.push_back(to_exp(part_m));
        ch_m = 0;
      end else ch_m++;
    end
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic wait_dout(input string tag);
    int n = 0;
    @(negedge clk);
    while (!dout_valid && n < 20) begin n++; @(negedge clk); end
    check(tag, dout_valid, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin n++; @(negedge clk); end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: in-order result compare plus hold-stability while back-pressured.
  always @(negedge clk) begin
    if (rst) held_v = 1'b0;
    else begin
      if (held_v) begin
        check("hold_valid", dout_valid, 1'b1);
        check("hold_dout", dout, held_d);
        check("hold_sat", sat_flag, held_s);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check("spurious_dout", dout_valid, 1'b0);
        else begin
          mon_e = exp_q.pop_front();
          check("dout", dout, mon_e.d);
          check("sat_flag", sat_flag, mon_e.s);
        end
      end
      held_v = dout_valid && !dout_ready;
      held_d = dout;
      held_s = sat_flag;
    end
  end

  initial begin
    rst = 1'b1; w_valid = 1'b0; win_valid = 1'b0; dout_ready = 1'b1;
    w_ch = '0; weights = '0; din = '0; ch_m = 0; part_m = 0; held_v = 1'b0;
    for (int c = 0; c < NCH; c++) for (int i = 0; i < KK; i++) wm[c][i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_sat", sat_flag, 1'b0);
    check("rst_win_ready", win_ready, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("w_ready_before_edge", w_ready, 1'b0);
    @(negedge clk);
    check("w_ready_after_edge", w_ready, 1'b1);
    @(posedge clk); #1;

    // Windows refused while weights incomplete
    send_w(0, fill(ONE));
    win_valid = 1'b1; din = fill(ONE);
    repeat (5) begin
      @(negedge clk);
      check("partial_win_ready", win_ready, 1'b0);
      check("partial_dout_valid", dout_valid, 1'b0);
    end
    @(posedge clk); #1 win_valid = 1'b0;

    // Weight beat beats a simultaneous window in S_IDLE
    send_w(1, fill(ONE));
    w_valid = 1'b1; w_ch = 1'b1; weights = fill(ONE);
    win_valid = 1'b1; din = fill(ONE);
    @(negedge clk);
    check("prio_w_ready", w_ready, 1'b1);
    check("prio_win_ready", win_ready, 1'b0);
    @(posedge clk); #1 w_valid = 1'b0; win_valid = 1'b0;

    // All-ones sample: 18.0 exactly three cycles after the last window
    send_win(fill(ONE));
    send_win(fill(ONE));
    repeat (3) @(negedge clk);
    check("latency_early", dout_valid, 1'b0);
    @(negedge clk);
    check("latency_valid", dout_valid, 1'b1);
    check("ones_dout", dout, 32'h0120_0000);
    wait_drain();

    // Negative weights truncate toward -inf
    send_w(0, fill(NEGHALF));
    send_w(1, fill(NEGHALF));
    send_win(fill(ONE));
    send_win(fill(ONE));
    wait_dout("neg_timeout");
    check("neg_dout", dout, 32'hFF70_0000);
    wait_drain();

    // Overflow: clip or wrap depending on build
    send_w(0, fill(BIG));
    send_w(1, fill(BIG));
    send_win(fill(BIG));
    send_win(fill(BIG));
    wait_dout("big_timeout");
`ifdef CONV_SATURATE_EN
    check("big_dout", dout, 32'h7FFF_FFFF);
    check("big_sat", sat_flag, 1'b1);
`else
    check("big_dout", dout, 32'h0120_0000);
    check("big_sat", sat_flag, 1'b0);
`endif
    wait_drain();

    // Back-pressure: five stalled cycles, nothing lost or duplicated
    send_w(0, rand_vec(1));
    send_w(1, rand_vec(1));
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_win(rand_vec(1));
    wait_dout("stall_timeout");
    @(posedge clk); #1;
    win_valid = 1'b1; din = rand_vec(1);
    repeat (5) begin
      @(negedge clk);
      check("stall_win_ready", win_ready, 1'b0);
      check("stall_dout_valid", dout_valid, 1'b1);
    end
    @(posedge clk); #1 dout_ready = 1'b1;
    send_win(din);
    send_win(rand_vec(1));
    wait_drain();

    // Randomized streaming with periodic weight reloads and input gaps
    for (int s = 0; s < 24; s++) begin
      if (s % 6 == 0) begin
        send_w(0, rand_vec(int'($urandom_range(0, 1))));
        send_w(1, rand_vec(int'($urandom_range(0, 1))));
      end
      for (int c = 0; c < NCH; c++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        send_win(rand_vec(int'($urandom_range(0, 1))));
      end
    end
    wait_drain();

    // Reset mid-sample discards partial work and loaded weights
    send_win(rand_vec(1));
    rst = 1'b1;
    exp_q.delete();
    ch_m = 0;
    @(negedge clk);
    check("midrst_dout_valid", dout_valid, 1'b0);
    check("midrst_win_ready", win_ready, 1'b0);
    check("midrst_w_ready", w_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst_win_ready", win_ready, 1'b0);
    check("postrst_w_ready", w_ready, 1'b1);
    check("postrst_dout_valid", dout_valid, 1'b0);
    @(posedge clk); #1;
    send_w(0, rand_vec(1));
    send_w(1, rand_vec(1));
    send_win(rand_vec(1));
    send_win(rand_vec(1));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
